// File: rtl/tilemap_scheduler.sv
// rtl/tilemap_scheduler.sv - walks the tilemap row-major and issues one tile-drawer request per cell
module tilemap_scheduler #(
    parameter int MAP_COLS    = 20,
    parameter int MAP_ROWS    = 15,
    parameter int NUM_TILES   = 21,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [8:0]  map_addr,
    input  logic [7:0]  map_data,
    output logic [11:0] td_tile_address,
    output logic [7:0]  td_x_pos,
    output logic [7:0]  td_y_pos,
    output logic        td_draw,
    input  logic        td_active,
    output logic        busy,
    output logic        done,
    output logic        bad_tile,
    output logic        timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MAP,
        S_LATCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_ADVANCE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]  map_addr_q, map_addr_d;
    logic [11:0] tile_addr_q, tile_addr_d;
    logic [7:0]  x_pos_q, x_pos_d;
    logic [7:0]  y_pos_q, y_pos_d;
    logic        draw_q, draw_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bad_tile_q, bad_tile_d;
    logic        timeout_q, timeout_d;

    logic        idx_bad;
    logic [11:0] idx_ext;

    always_comb begin
        idx_bad = (map_data >= 8'(NUM_TILES));
        idx_ext = idx_bad ? 12'd0 : {7'd0, map_data[4:0]};

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        map_addr_d  = map_addr_q;
        tile_addr_d = tile_addr_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        draw_d      = draw_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bad_tile_d  = bad_tile_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished frame.
                if (start && !done_q) begin
                    bad_tile_d = 1'b0;
                    timeout_d  = 1'b0;
                    row_d      = 4'd0;
                    col_d      = 5'd0;
                    map_addr_d = 9'd0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH:    state_d = S_WAIT_MAP;
            S_WAIT_MAP: state_d = S_LATCH;
            S_LATCH: begin
                if (idx_bad) begin
                    bad_tile_d = 1'b1;
                end
                tile_addr_d = (idx_ext << 7) + (idx_ext << 6);
                x_pos_d     = {col_q, 3'b000};
                y_pos_d     = {1'b0, row_q, 3'b000};
                cnt_d       = '0;
                draw_d      = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                // Drop draw immediately on ack so the idle drawer cannot retrigger.
                if (td_active) begin
                    draw_d  = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    draw_d    = 1'b0;
                    state_d   = S_ADVANCE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!td_active) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (col_q == 5'(MAP_COLS - 1)) begin
                    col_d = 5'd0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                map_addr_d = map_addr_q + 9'd1;
                if (row_q == 4'(MAP_ROWS - 1) && col_q == 5'(MAP_COLS - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= 5'd0;
            row_q       <= 4'd0;
            cnt_q       <= '0;
            map_addr_q  <= 9'd0;
            tile_addr_q <= 12'd0;
            x_pos_q     <= 8'd0;
            y_pos_q     <= 8'd0;
            draw_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bad_tile_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            map_addr_q  <= map_addr_d;
            tile_addr_q <= tile_addr_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            draw_q      <= draw_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bad_tile_q  <= bad_tile_d;
            timeout_q   <= timeout_d;
        end
    end

    assign map_addr        = map_addr_q;
    assign td_tile_address = tile_addr_q;
    assign td_x_pos        = x_pos_q;
    assign td_y_pos        = y_pos_q;
    assign td_draw         = draw_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign bad_tile        = bad_tile_q;
    assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_tilemap_scheduler.sv
// tb/tb_tilemap_scheduler.sv - scoreboard bench for tilemap_scheduler with RAM and drawer models
module tb_tilemap_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  map_addr;
    logic [7:0]  map_data;
    logic [11:0] td_tile_address;
    logic [7:0]  td_x_pos;
    logic [7:0]  td_y_pos;
    logic        td_draw;
    logic        td_active;
    logic        busy;
    logic        done;
    logic        bad_tile;
    logic        timeout_err;

    tilemap_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .map_addr        (map_addr),
        .map_data        (map_data),
        .td_tile_address (td_tile_address),
        .td_x_pos        (td_x_pos),
        .td_y_pos        (td_y_pos),
        .td_draw         (td_draw),
        .td_active       (td_active),
        .busy            (busy),
        .done            (done),
        .bad_tile        (bad_tile),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [8:0]  maddr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] map_mem [300];
    int         checks = 0;
    int         passed = 0;
    int         draws = 0;
    int         acks = 0;
    int         done_cnt = 0;
    logic       noack_en = 1'b0;
    int         noack_cell = 7;
    logic [7:0] last_x, last_y;
    localparam int DUR = 2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Tilemap RAM (one-cycle latency) and tile drawer model.
    initial begin
        logic [8:0] s_addr;
        logic       s_draw;
        int         act_cnt;
        td_active = 1'b0;
        map_data  = 8'd0;
        act_cnt   = 0;
        forever begin
            @(negedge clk);
            s_addr = map_addr;
            s_draw = td_draw;
            @(posedge clk);
            #1;
            map_data = (s_addr < 9'd300) ? map_mem[s_addr] : 8'd0;
            if (td_active) begin
                if (act_cnt == 0) td_active = 1'b0;
                else act_cnt--;
            end else if (s_draw && !(noack_en && int'(s_addr) == noack_cell)) begin
                td_active = 1'b1;
                act_cnt   = DUR;
                acks++;
            end
        end
    end

    // Monitor: every rising td_draw is matched against the scoreboard.
    initial begin
        logic draw_prev;
        int   draw_len;
        exp_t e;
        logic [8:0] cur_maddr;
        draw_prev = 1'b0;
        draw_len  = 0;
        cur_maddr = 9'd0;
        forever begin
            @(negedge clk);
            if (td_draw && !draw_prev) begin
                draws++;
                draw_len  = 1;
                cur_maddr = map_addr;
                last_x    = td_x_pos;
                last_y    = td_y_pos;
                if (exp_q.size() == 0) begin
                    chk("unexpected_draw", 64'(map_addr), 64'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("draw_cell%0d", e.maddr),
                        64'({td_tile_address, td_x_pos, td_y_pos, map_addr}), 64'(e));
                end
            end else if (td_draw) begin
                draw_len++;
            end else if (draw_prev && noack_en && int'(cur_maddr) == noack_cell) begin
                chk("timeout_draw_len", 64'(draw_len), 64'd15);
            end
            if (done) done_cnt++;
            draw_prev = td_draw;
        end
    end

    task automatic push_frame();
        exp_t e;
        int   idx;
        for (int i = 0; i < 300; i++) begin
            idx = int'(map_mem[i]);
            if (idx >= 21) idx = 0;
            e.addr  = 12'(idx * 192);
            e.x     = 8'((i % 20) * 8);
            e.y     = 8'((i / 20) * 8);
            e.maddr = 9'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        draws    = 0;
        acks     = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("flags_cleared", 64'({bad_tile, timeout_err}), 64'd0);
    endtask

    task automatic wait_done(input int mid_at, output int cyc);
        logic pulsed;
        cyc    = 0;
        pulsed = 1'b0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (start) start = 1'b0;
            if (mid_at >= 0 && !pulsed && draws == mid_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        if (done !== 1'b1) chk("done_within_bound", 64'(done), 64'd1);
    endtask

    task automatic frame_end_checks(input int exp_acks);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("draw_count", 64'(draws), 64'd300);
        chk("ack_count", 64'(acks), 64'(exp_acks));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("last_pos", 64'({last_x, last_y}), 64'({8'd152, 8'd112}));
    endtask

    initial begin
        int cyc_ref, cyc, guard;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 300; i++) map_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({map_addr, td_tile_address, td_x_pos, td_y_pos,
                                  td_draw, busy, done, bad_tile, timeout_err}), 64'd0);
        reset = 1'b0;

        // Frame 1: all index 0, reference timing.
        push_frame();
        start_frame();
        wait_done(-1, cyc_ref);
        frame_end_checks(300);
        chk("frame1_flags", 64'({bad_tile, timeout_err}), 64'd0);

        // Frame 2: varied indices, one out-of-range at cell 0 and cell 100.
        for (int i = 0; i < 300; i++) map_mem[i] = 8'((i * 7) % 21);
        map_mem[0]   = 8'd25;
        map_mem[43]  = 8'd5;
        map_mem[100] = 8'd255;
        map_mem[299] = 8'd20;
        push_frame();
        start_frame();
        wait_done(-1, cyc);
        chk("bad_tile_sticky", 64'({bad_tile, timeout_err}), 64'b10);
        frame_end_checks(300);

        // Frame 3: drawer never acks cell 7; start clears bad_tile.
        for (int i = 0; i < 300; i++) map_mem[i] = 8'd0;
        noack_en = 1'b1;
        push_frame();
        start_frame();
        wait_done(-1, cyc);
        chk("timeout_err_set", 64'({bad_tile, timeout_err}), 64'b01);
        frame_end_checks(299);
        noack_en = 1'b0;

        // Frame 4: start pulsed while cell 100 is in flight is ignored.
        push_frame();
        start_frame();
        wait_done(101, cyc);
        chk("midframe_start_timing", 64'(cyc), 64'(cyc_ref));
        frame_end_checks(300);

        // Frame 5: reset during WAIT_DONE of cell 50, then restart from cell 0.
        push_frame();
        start_frame();
        guard = 0;
        while (!(draws == 51 && td_active && !td_draw) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_cell50_wait_done", 64'(draws), 64'd51);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midframe_reset_outputs", 64'({map_addr, td_tile_address, td_x_pos, td_y_pos,
                                           td_draw, busy, done, bad_tile, timeout_err}), 64'd0);
        exp_q.delete();
        guard = 0;
        while (td_active && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drawer_idle_after_reset", 64'(td_active), 64'd0);
        push_frame();
        start_frame();
        wait_done(-1, cyc);
        chk("restart_timing", 64'(cyc), 64'(cyc_ref));
        frame_end_checks(300);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
